seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Parameter SIGNED_EN, default 1: 1 enables the signed_mode input; 0 forces unsigned operation.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 signed_mode  input  1  two's-complement operation when high and SIGNED_EN=1; sampled with start.
REQ-007 in1  input  WIDTH  dividend; sampled with start.
REQ-008 in2  input  WIDTH  divisor; sampled with start.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 out  output  WIDTH  quotient.
REQ-012 rem  output  WIDTH  remainder.
REQ-013 dbz  output  1  divide-by-zero flag for the current result.
REQ-014 ovf  output  1  signed overflow flag for the current result.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE; it leaves IDLE only when start=1.
REQ-016 IDLE->RUN: operands and mode are registered, signed operands are converted to magnitudes, and the iteration counter is loaded with WIDTH-1.
REQ-017 RUN SHALL perform one restoring radix-2 step per cycle, MSB first: shift the partial remainder left, shift in the next dividend bit, and subtract the divisor if the result is non-negative; it runs for exactly WIDTH cycles, then moves to DONE.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high during the cycle following edge k+WIDTH+1; DONE->IDLE is unconditional.
REQ-019 out, rem, dbz and ovf SHALL update at the entry to DONE and hold until the next accepted start; no other event changes them except reset.
REQ-020 start while busy or in DONE SHALL be ignored; operand changes during RUN SHALL have no effect.
REQ-021 in2=0: the FSM skips RUN (IDLE->DONE), done is high after edge k+1, dbz=1, out is all ones, rem=in1, ovf=0.
REQ-022 Unsigned: out=floor(in1/in2), rem=in1-out*in2.
REQ-023 Signed: the quotient truncates toward zero and is negated when the operand signs differ; rem takes the sign of the dividend; |rem|<|in2|.
REQ-024 Signed most-negative/-1: out=most-negative value (wrap), rem=0, ovf=1; in every other case ovf=0.
REQ-025 in1<in2 (unsigned magnitude) SHALL give out=0, rem=in1, still with full WIDTH-cycle latency; no early-exit path other than dbz.

Reset
REQ-026 Asserting rst at any time, including mid-RUN, SHALL force IDLE and clear busy, done, out, rem, dbz, ovf and all internal registers to 0 immediately.
REQ-027 After rst deasserts, the first start SHALL be accepted normally with no residue from the aborted operation.

Structure
REQ-028 A shared package seq_div_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the counter-width function clog2(WIDTH).
REQ-029 The signed magnitude/negation logic SHALL be one sub-module, div_sign_fix, instantiated once at input (abs) and once at output (result sign correction).
REQ-030 Only the datapath (partial remainder, quotient shift register, counter) is clocked; there are no combinational paths from inputs to outputs.

Verification
REQ-031 WIDTH=8, unsigned, 200/7 -> out=28, rem=4, dbz=0, one done pulse exactly 9 edges after start.
REQ-032 Signed -7/2 (8'hF9/8'h02) -> out=8'hFD, rem=8'hFF; signed 7/-2 -> out=8'hFD, rem=8'h01.
REQ-033 Signed 8'h80/8'hFF -> out=8'h80, rem=0, ovf=1; unsigned 8'h80/8'hFF -> out=0, rem=8'h80, ovf=0.
REQ-034 in1=55, in2=0 -> done one edge after start, dbz=1, out=8'hFF, rem=55.
REQ-035 Start 100/3, pulse start with 9/9 at RUN cycle 3, assert rst at RUN cycle 5 -> all outputs 0 immediately; a fresh 9/9 then gives out=1, rem=0.
REQ-036 Randomised regression at WIDTH=8 and WIDTH=16, both modes, checked against a reference model.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and elaboration helpers for the sequential restoring divider.
// Holds the FSM state encoding and the per-operation sign/overflow flags.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Captured at accept time so the result can be sign-corrected after the last step.
  typedef struct packed {
    logic neg_quo;
    logic neg_rem;
    logic ovf;
  } op_flags_t;

  // Bits needed to hold values 0 .. value-1; used to size the iteration counter.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a pair of operands.
// Used once to take magnitudes of the inputs and once to sign-correct the results.
module div_sign_fix
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             neg_b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  assign a_o = neg_a_i ? (~a_i + WIDTH'(1)) : a_i;
  assign b_o = neg_b_i ? (~b_i + WIDTH'(1)) : b_i;

endmodule

// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, MSB first.
// Signed operation works on magnitudes and fixes the signs on the way out.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             ovf
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  op_flags_t        flags_q, flags_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             in_signed;
  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             accept;
  logic             div_zero;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] res_quo, res_rem;

  assign in_signed = SIGNED_EN && signed_mode;
  assign neg1      = in_signed && in1[WIDTH-1];
  assign neg2      = in_signed && in2[WIDTH-1];
  assign accept    = (state_q == IDLE) && start;
  assign div_zero  = (in2 == '0);
  assign last_step = (state_q == RUN) && (cnt_q == '0);

  div_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .a_i     (in1),
    .neg_a_i (neg1),
    .b_i     (in2),
    .neg_b_i (neg2),
    .a_o     (mag1),
    .b_o     (mag2)
  );

  // One restoring step: bring down the next dividend bit, keep the difference if it fits.
  assign shifted  = {prem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign fits     = ~trial[WIDTH];
  assign step_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], fits};

  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .a_i     (step_quo),
    .neg_a_i (flags_q.neg_quo),
    .b_i     (step_rem),
    .neg_b_i (flags_q.neg_rem),
    .a_o     (res_quo),
    .b_o     (res_rem)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = div_zero ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    if (accept) begin
      prem_d          = '0;
      quo_d           = mag1;
      dvs_d           = mag2;
      cnt_d           = CNT_LOAD;
      flags_d.neg_quo = neg1 ^ neg2;
      flags_d.neg_rem = neg1;
      flags_d.ovf     = in_signed && (in1 == MIN_VAL) && (in2 == '1);
      // Zero divisor bypasses RUN, so its results are published right away.
      if (div_zero) begin
        out_d = '1;
        rem_d = in1;
        dbz_d = 1'b1;
        ovf_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      prem_d = step_rem;
      quo_d  = step_quo;
      cnt_d  = cnt_q - CNT_W'(1);
      if (last_step) begin
        out_d = res_quo;
        rem_d = res_rem;
        dbz_d = 1'b0;
        ovf_d = flags_q.ovf;
      end
    end
  end

  // NOTE: all datapath registers are reset, so an aborted division leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prem_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out = out_q;
  assign rem = rem_q;
  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div at WIDTH=8 and WIDTH=16: directed vector table,
// hand-written multi-cycle sequences, and randomized runs against an arithmetic model.
module tb_seq_div;

  logic clk;
  logic rst;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8, ovf8;
  logic [7:0]  out8, rem8;

  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16, dbz16, ovf16;
  logic [15:0] out16, rem16;

  int errors = 0;
  int checks = 0;

  seq_div #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .in1(a8), .in2(b8),
    .busy(busy8), .done(done8), .out(out8), .rem(rem8), .dbz(dbz8), .ovf(ovf8)
  );

  seq_div #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .in1(a16), .in2(b16),
    .busy(busy16), .done(done16), .out(out16), .rem(rem16), .dbz(dbz16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int          w;
    bit          sgn;
    logic [31:0] a, b, q, r;
    logic        dz, ov;
  } vec_t;

  typedef struct packed {
    logic [31:0] q, r;
    logic        done, busy, dz, ov;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t observe(input int w);
    obs_t o;
    if (w == 8) begin
      o = '{q: {24'b0, out8}, r: {24'b0, rem8}, done: done8, busy: busy8, dz: dbz8, ov: ovf8};
    end else begin
      o = '{q: {16'b0, out16}, r: {16'b0, rem16}, done: done16, busy: busy16, dz: dbz16, ov: ovf16};
    end
    return o;
  endfunction

  task automatic drive(input int w, input logic s, input bit sgn, input logic [31:0] a, b);
    if (w == 8) begin
      start8 = s; sm8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = s; sm16 = sgn; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  // Reference: plain integer division with the signed rules applied directly.
  function automatic void ref_div(input int w, input bit sgn, input logic [31:0] a, b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
    longint mask, sa, sb;
    mask = (longint'(1) << w) - 1;
    q = '0; r = '0; dz = 1'b0; ov = 1'b0;
    if (b == 0) begin
      q = 32'(mask); r = a; dz = 1'b1;
    end else if (sgn) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
        q = 32'(sa & mask); r = '0; ov = 1'b1;
      end else begin
        q = 32'((sa / sb) & mask);
        r = 32'((sa % sb) & mask);
      end
    end else begin
      q = 32'(longint'(a) / longint'(b));
      r = 32'(longint'(a) % longint'(b));
    end
  endfunction

  // Issues one division and counts edges from the accepting edge until done is seen.
  task automatic do_op(input int w, input bit sgn, input logic [31:0] a, b,
                       output obs_t res, output int edges);
    @(negedge clk);
    drive(w, 1'b1, sgn, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, sgn, a, b);
    edges = 1;
    while (!observe(w).done && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    res = observe(w);
  endtask

  task automatic run_and_check(input string name, input int w, input bit sgn,
                               input logic [31:0] a, b, eq, er, input logic edz, eov);
    obs_t res;
    int   edges;
    do_op(w, sgn, a, b, res, edges);
    check({name, " quo"}, res.q, eq);
    check({name, " rem"}, res.r, er);
    check({name, " dbz"}, {31'b0, res.dz}, {31'b0, edz});
    check({name, " ovf"}, {31'b0, res.ov}, {31'b0, eov});
    check({name, " latency"}, edges, edz ? 1 : w + 1);
    @(posedge clk); #1;
    check({name, " done pulse"}, {31'b0, observe(w).done}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    obs_t o;
    int   edges;

    vecs = '{
      '{8,  1'b0, 32'd200,   32'd7,     32'd28,    32'd4,     1'b0, 1'b0},
      '{8,  1'b1, 32'hF9,    32'h02,    32'hFD,    32'hFF,    1'b0, 1'b0},
      '{8,  1'b1, 32'h07,    32'hFE,    32'hFD,    32'h01,    1'b0, 1'b0},
      '{8,  1'b1, 32'h80,    32'hFF,    32'h80,    32'h00,    1'b0, 1'b1},
      '{8,  1'b0, 32'h80,    32'hFF,    32'h00,    32'h80,    1'b0, 1'b0},
      '{8,  1'b0, 32'd55,    32'd0,     32'hFF,    32'd55,    1'b1, 1'b0},
      '{8,  1'b0, 32'd3,     32'd10,    32'd0,     32'd3,     1'b0, 1'b0},
      '{8,  1'b1, 32'h80,    32'h01,    32'h80,    32'h00,    1'b0, 1'b0},
      '{8,  1'b1, 32'hF9,    32'hFC,    32'h01,    32'hFD,    1'b0, 1'b0},
      '{8,  1'b0, 32'hFF,    32'hFF,    32'h01,    32'h00,    1'b0, 1'b0},
      '{8,  1'b1, 32'h00,    32'h00,    32'hFF,    32'h00,    1'b1, 1'b0},
      '{16, 1'b0, 32'd1000,  32'd7,     32'd142,   32'd6,     1'b0, 1'b0},
      '{16, 1'b1, 32'h8000,  32'hFFFF,  32'h8000,  32'h0000,  1'b0, 1'b1},
      '{16, 1'b1, 32'hFC18,  32'h0007,  32'hFF72,  32'hFFFA,  1'b0, 1'b0},
      '{16, 1'b0, 32'hFFFF,  32'h0000,  32'hFFFF,  32'hFFFF,  1'b1, 1'b0}
    };

    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 0, 0);
    drive(16, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    o = observe(8);
    check("reset quo8", o.q, 0);
    check("reset rem8", o.r, 0);
    check("reset flags8", {28'b0, o.done, o.busy, o.dz, o.ov}, 0);
    o = observe(16);
    check("reset quo16", o.q, 0);
    check("reset flags16", {28'b0, o.done, o.busy, o.dz, o.ov}, 0);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
    end

    // Operand changes and a second start during RUN must not disturb 100/3.
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 100, 3);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 250, 1);
    @(posedge clk); #1;
    check("run busy", {31'b0, busy8}, 1);
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 9, 9);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 77, 5);
    edges = 0;
    while (!done8 && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ignore quo", {24'b0, out8}, 33);
    check("ignore rem", {24'b0, rem8}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold quo", {24'b0, out8}, 33);
    check("hold rem", {24'b0, rem8}, 1);
    check("hold idle busy", {30'b0, busy8, done8}, 0);

    // Reset mid-RUN: start 100/3, poke 9/9 at RUN cycle 3, reset at RUN cycle 5.
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 100, 3);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 100, 3);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 9, 9);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 9, 9);
    @(posedge clk);
    @(negedge clk);
    check("pre-reset busy", {31'b0, busy8}, 1);
    #2;
    rst = 1'b1;
    #1;
    o = observe(8);
    check("abort quo", o.q, 0);
    check("abort rem", o.r, 0);
    check("abort flags", {28'b0, o.done, o.busy, o.dz, o.ov}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", {30'b0, busy8, done8}, 0);
    run_and_check("fresh 9/9", 8, 1'b0, 9, 9, 1, 0, 1'b0, 1'b0);

    for (int ws = 0; ws < 2; ws++) begin
      for (int i = 0; i < 150; i++) begin
        int          w;
        logic [31:0] mask, a, b, eq, er;
        logic        edz, eov;
        bit          sgn;
        int          pick;
        w    = (ws == 0) ? 8 : 16;
        mask = (w == 8) ? 32'hFF : 32'hFFFF;
        sgn  = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 15);
        a    = $urandom & mask;
        b    = $urandom & mask;
        if (pick == 0) b = 0;
        if (pick == 1) b = mask;
        if (pick == 2) begin
          a = 32'h1 << (w - 1);
          b = mask;
        end
        if (pick == 3) b = b >> (w / 2);
        ref_div(w, sgn, a, b, eq, er, edz, eov);
        run_and_check($sformatf("rnd w%0d s%0d %0h/%0h", w, sgn, a, b),
                      w, sgn, a, b, eq, er, edz, eov);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
